// File: rtl/serial_adder_ctrl_if.sv
//------------------------------------------------------------------------------
// Module : serial_adder_ctrl_if
// Brief  : Host/adder handshake bundle; sub exists only with SERIAL_SUB_EN.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
//------------------------------------------------------------------------------
// Module : serial_adder_ctrl
// Brief  : Bit-serial WIDTH-bit adder, LSB first, one full adder reused per
//          bit. Optional subtract mode under macro SERIAL_SUB_EN.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_adder_ctrl_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);
  assign o_s  = i_a ^ i_b ^ i_ci;
  assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_adder_ctrl_if.slave bus
);
  localparam int                 c_CNT_W = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_load;
  logic               w_busy;
  logic               w_done;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic               r_cout;
  logic [c_CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0]   w_b_in;
  logic               w_c_in;
  logic               w_s;
  logic               w_co;

`ifdef SERIAL_SUB_EN
  // Two's-complement subtract: invert B and inject a carry of one.
  assign w_b_in = bus.sub ? ~bus.b : bus.b;
  assign w_c_in = bus.sub | bus.cin;
`else
  assign w_b_in = bus.b;
  assign w_c_in = bus.cin;
`endif

  serial_adder_ctrl_fa u_fa (
    .i_a  (r_a[0]),
    .i_b  (r_b[0]),
    .i_ci (r_carry),
    .o_s  (w_s),
    .o_co (w_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_load = 1'b1;
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (r_cnt == c_LAST) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        if (bus.start) begin
          w_load = 1'b1;
          w_next = S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_a     <= bus.a;
      r_b     <= w_b_in;
      r_carry <= w_c_in;
      r_cnt   <= '0;
    end else if (w_busy) begin
      // Each sum bit enters at the MSB so bit 0 lands at index 0 after WIDTH shifts.
      r_sum   <= {w_s, r_sum[WIDTH-1:1]};
      r_carry <= w_co;
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_cnt   <= r_cnt + 1'b1;
      if (r_cnt == c_LAST) begin
        r_cout <= w_co;
      end
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule

`default_nettype wire
